// File: rtl/f_feat_pkg.sv
// Shared types and constants for the line-length feature window.
// Optional windowed-energy path is enabled with `define LL_ENERGY_EN.
package f_feat_pkg;

  localparam int SAMPLE_W   = 32;
  localparam int DIFF_W     = 33;
  localparam int SQ_W       = 64;
  localparam int DEF_WIN    = 256;
  localparam int DEF_ACC_W  = 48;
  localparam int DEF_ESHIFT = 24;

  typedef enum logic [0:0] {
    S_PRIME = 1'b0,   // no previous sample held yet
    S_ACC   = 1'b1    // prev valid, diffs accumulate
  } feat_state_e;

  // |a - b| in 33-bit signed; the magnitude of two 32-bit signed values
  // always fits 33 bits unsigned, so there is no wrap.
  function automatic logic [DIFF_W-1:0] abs_diff(input logic signed [SAMPLE_W-1:0] a,
                                                 input logic signed [SAMPLE_W-1:0] b);
    logic signed [DIFF_W-1:0] df;
    df = $signed({a[SAMPLE_W-1], a}) - $signed({b[SAMPLE_W-1], b});
    return df[DIFF_W-1] ? DIFF_W'(-df) : DIFF_W'(df);
  endfunction

endpackage

// File: rtl/sat_accum.sv
// Saturating accumulator with sticky saturation flag and sync clear.
// sum_next/flag_next expose the value the accumulator would take this
// cycle so the caller can capture a window total on its final sample.
module sat_accum #(
  parameter int W    = 48,
  parameter int IN_W = 33
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            clr,
  input  logic [IN_W-1:0] d,
  output logic [W-1:0]    sum_next,
  output logic            flag_next
);

  localparam int SW = ((W > IN_W) ? W : IN_W) + 1;

  logic [W-1:0]  acc;
  logic          flag;
  logic [SW-1:0] sum_w;
  logic          add_ovf;

  // widened add; any bit above W means the true sum exceeds the range
  always_comb begin
    sum_w     = SW'(acc) + SW'(d);
    add_ovf   = |sum_w[SW-1:W];
    sum_next  = add_ovf ? {W{1'b1}} : sum_w[W-1:0];
    flag_next = flag | add_ovf;
  end

  // clear wins over accumulate so a window restart drops the current input
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      acc  <= '0;
      flag <= 1'b0;
    end else if (en) begin
      acc  <= sum_next;
      flag <= flag_next;
    end
  end

endmodule

// File: rtl/ll_feature_win.sv
// Line-length feature over non-overlapping windows of WIN accepted samples.
// Emits sum |x[n]-x[n-1]| with a one-cycle out_valid per window.
// `define LL_ENERGY_EN adds a saturating (x*x)>>ESHIFT energy accumulator.
module ll_feature_win
  import f_feat_pkg::*;
#(
  parameter int WIN    = DEF_WIN,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int ESHIFT = DEF_ESHIFT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic signed [SAMPLE_W-1:0] x,
  input  logic                       clear,
  output logic                       out_valid,
  output logic [ACC_W-1:0]           ll_out,
  output logic                       ovf,
  output logic [ACC_W-1:0]           energy_out
);

  localparam int CNT_W = $clog2(WIN + 1);

  if (WIN < 1 || ACC_W < 33 || ESHIFT < 0 || ESHIFT > 63) begin : g_bad_param
    $error("ll_feature_win: illegal WIN/ACC_W/ESHIFT");
  end

  feat_state_e                state;
  logic signed [SAMPLE_W-1:0] prev;
  logic [CNT_W-1:0]           count;
  logic                       acc_en;
  logic                       last;
  logic                       done;
  logic                       win_clr;
  logic [DIFF_W-1:0]          diff;
  logic [ACC_W-1:0]           ll_sum_next;
  logic                       ll_flag_next;
  logic                       e_flag_next;

  // a sample presented with clear is discarded; done marks the window's final sample
  always_comb begin
    acc_en  = in_valid & ~clear;
    last    = (count == CNT_W'(WIN - 1));
    done    = acc_en & last;
    win_clr = clear | done;
    diff    = (state == S_PRIME) ? '0 : abs_diff(x, prev);
  end

  sat_accum #(.W(ACC_W), .IN_W(DIFF_W)) u_ll_acc (
    .clk       (clk),
    .reset     (reset),
    .en        (acc_en),
    .clr       (win_clr),
    .d         (diff),
    .sum_next  (ll_sum_next),
    .flag_next (ll_flag_next)
  );

`ifdef LL_ENERGY_EN
  logic signed [SQ_W-1:0] sq;
  logic [SQ_W-1:0]        e_d;
  logic [ACC_W-1:0]       e_sum_next;

  // square is non-negative, so the shift can be logical
  always_comb begin
    sq  = SQ_W'(x) * SQ_W'(x);
    e_d = sq >> ESHIFT;
  end

  sat_accum #(.W(ACC_W), .IN_W(SQ_W)) u_e_acc (
    .clk       (clk),
    .reset     (reset),
    .en        (acc_en),
    .clr       (win_clr),
    .d         (e_d),
    .sum_next  (e_sum_next),
    .flag_next (e_flag_next)
  );

  // energy is emitted alongside ll_out with the same pulse
  always_ff @(posedge clk) begin
    if (reset)     energy_out <= '0;
    else if (done) energy_out <= e_sum_next;
  end
`else
  assign e_flag_next = 1'b0;
  assign energy_out  = '0;
`endif

  // FSM, previous sample and window count; prev survives window boundaries
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_PRIME;
      prev  <= '0;
      count <= '0;
    end else if (clear) begin
      state <= S_PRIME;
      count <= '0;
    end else if (acc_en) begin
      state <= S_ACC;
      prev  <= x;
      count <= last ? '0 : count + 1'b1;
    end
  end

  // registered window result; outputs hold between pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      ll_out    <= '0;
      ovf       <= 1'b0;
    end else begin
      out_valid <= done;
      if (done) begin
        ll_out <= ll_sum_next;
        ovf    <= ll_flag_next | e_flag_next;
      end
    end
  end

endmodule

// File: tb/tb_ll_feature_win.sv
// Self-checking bench for ll_feature_win: two instances (ACC_W=48, ACC_W=33),
// WIN=4, ESHIFT=0, shared stimulus, scoreboard queue per instance.
module tb_ll_feature_win;

  localparam int WIN = 4;
  localparam int ESH = 0;

  logic               clk = 1'b0;
  logic               reset, in_valid, clear;
  logic signed [31:0] x;
  logic               ov_a, ovf_a, ov_b, ovf_b;
  logic [47:0]        ll_a, en_a;
  logic [32:0]        ll_b, en_b;

  always #5 clk = ~clk;

  ll_feature_win #(.WIN(WIN), .ACC_W(48), .ESHIFT(ESH)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .x(x), .clear(clear),
    .out_valid(ov_a), .ll_out(ll_a), .ovf(ovf_a), .energy_out(en_a));

  ll_feature_win #(.WIN(WIN), .ACC_W(33), .ESHIFT(ESH)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .x(x), .clear(clear),
    .out_valid(ov_b), .ll_out(ll_b), .ovf(ovf_b), .energy_out(en_b));

  typedef struct {
    int unsigned due;
    logic [64:0] ll;
    logic        ovf;
    logic [64:0] en;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int npass = 0;
  int ntot  = 0;
  int unsigned cyc = 0;

  int          aw[2] = '{48, 33};
  logic [64:0] m_acc[2], m_eacc[2], l_ll[2], l_en[2];
  logic        m_f[2], m_ef[2], l_ovf[2], m_prime[2];
  int          m_cnt[2];
  logic signed [31:0] m_prev[2];

  task automatic chk(input string tag, input int k, input logic [64:0] obs, input logic [64:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s[dut%0d] cyc=%0d observed=%0d expected=%0d", tag, k, cyc, obs, exp);
  endtask

  task automatic model(input int k, input logic rst, input logic v,
                       input logic signed [31:0] xv, input logic clr);
    logic [64:0] mx, s, e;
    longint      xs, ps, df;
    logic [63:0] dfu, squ;
    exp_t        ex;
    mx = (65'd1 << aw[k]) - 65'd1;
    if (rst) begin
      m_acc[k] = '0; m_eacc[k] = '0; m_f[k] = 1'b0; m_ef[k] = 1'b0;
      m_cnt[k] = 0; m_prime[k] = 1'b1; m_prev[k] = '0;
      l_ll[k] = '0; l_en[k] = '0; l_ovf[k] = 1'b0;
      if (k == 0) q0.delete(); else q1.delete();
    end else if (clr) begin
      m_acc[k] = '0; m_eacc[k] = '0; m_f[k] = 1'b0; m_ef[k] = 1'b0;
      m_cnt[k] = 0; m_prime[k] = 1'b1;
    end else if (v) begin
      xs = longint'(xv);
      ps = longint'(m_prev[k]);
      df = m_prime[k] ? 64'sd0 : xs - ps;
      if (df < 0) df = -df;
      dfu = df;
      s = m_acc[k] + {1'b0, dfu};
      if (s > mx) begin s = mx; m_f[k] = 1'b1; end
      m_acc[k] = s;
`ifdef LL_ENERGY_EN
      squ = xs * xs;
      e = m_eacc[k] + ({1'b0, squ} >> ESH);
      if (e > mx) begin e = mx; m_ef[k] = 1'b1; end
      m_eacc[k] = e;
`else
      squ = '0;
      e = '0;
`endif
      m_prev[k] = xv;
      m_prime[k] = 1'b0;
      m_cnt[k]++;
      if (m_cnt[k] == WIN) begin
        ex.due = cyc + 1;
        ex.ll  = m_acc[k];
        ex.ovf = m_f[k] | m_ef[k];
        ex.en  = m_eacc[k];
        if (k == 0) q0.push_back(ex); else q1.push_back(ex);
        m_acc[k] = '0; m_eacc[k] = '0; m_f[k] = 1'b0; m_ef[k] = 1'b0; m_cnt[k] = 0;
      end
    end
  endtask

  task automatic mon(input int k, input logic ov, input logic [64:0] ll,
                     input logic ovf, input logic [64:0] en);
    logic exp_v;
    exp_t ex;
    if (k == 0) exp_v = (q0.size() > 0) && (q0[0].due == cyc);
    else        exp_v = (q1.size() > 0) && (q1[0].due == cyc);
    chk("out_valid", k, {64'd0, ov}, {64'd0, exp_v});
    if (exp_v) begin
      if (k == 0) ex = q0.pop_front(); else ex = q1.pop_front();
      l_ll[k] = ex.ll; l_ovf[k] = ex.ovf; l_en[k] = ex.en;
    end
    chk("ll_out", k, ll, l_ll[k]);
    chk("ovf", k, {64'd0, ovf}, {64'd0, l_ovf[k]});
    chk("energy_out", k, en, l_en[k]);
  endtask

  task automatic step(input logic rst, input logic v, input logic signed [31:0] xv, input logic clr);
    reset = rst; in_valid = v; x = xv; clear = clr;
    model(0, rst, v, xv, clr);
    model(1, rst, v, xv, clr);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    mon(0, ov_a, 65'(ll_a), ovf_a, 65'(en_a));
    mon(1, ov_b, 65'(ll_b), ovf_b, 65'(en_b));
  endtask

  task automatic samp(input logic signed [31:0] xv); step(1'b0, 1'b1, xv, 1'b0); endtask
  task automatic idle(); step(1'b0, 1'b0, 32'sd12345, 1'b0); endtask
  task automatic do_reset(); step(1'b1, 1'b0, 32'sd0, 1'b0); step(1'b1, 1'b0, 32'sd0, 1'b0); endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; clear = 1'b0; x = '0;
    @(negedge clk);
    do_reset();

    // constant input: zero line-length in both windows
    for (int i = 0; i < 8; i++) samp(32'sd100);
    idle(); idle();

    // alternating +-1000, continuous: 6000 then 8000
    do_reset();
    for (int i = 0; i < 8; i++) samp((i % 2 == 0) ? 32'sd1000 : -32'sd1000);
    idle(); idle();

    // same pattern gapped 1 of 3 cycles with junk x in the gaps
    do_reset();
    for (int i = 0; i < 8; i++) begin
      samp((i % 2 == 0) ? 32'sd1000 : -32'sd1000);
      idle(); idle();
    end

    // full-scale alternation: d=2^32-1, saturates the 33-bit instance
    do_reset();
    for (int i = 0; i < 8; i++) samp((i % 2 == 0) ? 32'sh7FFFFFFF : 32'sh80000000);
    idle(); idle();

    // constant 1000: energy 4000000 when the energy path is built
    do_reset();
    for (int i = 0; i < 4; i++) samp(32'sd1000);
    idle();

    // reset mid-window drops the partial window; restart with diff 0
    samp(32'sd7000); samp(-32'sd7000);
    do_reset();
    for (int i = 0; i < 4; i++) samp((i % 2 == 0) ? 32'sd1000 : -32'sd1000);
    idle();

    // clear mid-window with a sample in the same cycle: that sample is dropped
    samp(32'sd5000); samp(-32'sd5000);
    step(1'b0, 1'b1, 32'sd90000, 1'b1);
    for (int i = 0; i < 4; i++) samp((i % 2 == 0) ? 32'sd1000 : -32'sd1000);
    // clear right after completion: pending pulse still fires
    step(1'b0, 1'b0, 32'sd0, 1'b1);
    for (int i = 0; i < 4; i++) samp(32'sd300 * i);
    idle();

    // random mix of gaps, clears and magnitudes
    for (int i = 0; i < 120; i++) begin
      logic        v, c;
      logic [31:0] r;
      v = ($urandom_range(0, 2) != 0);
      c = ($urandom_range(0, 24) == 0);
      r = (i % 3 == 0) ? $urandom() : 32'($urandom_range(0, 4000)) - 32'd2000;
      step(1'b0, v, $signed(r), c);
    end
    idle(); idle();

    chk("queue_drained", 0, 65'(q0.size() + q1.size()), 65'd0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
